instr_encoder: RTL

Streaming RV64I+Zba instruction encoder: accepts symbolic instruction requests (kind, registers, immediate) over a valid/ready handshake and emits 32-bit machine words. The words go into a small FIFO and drain to an instruction-memory write port, each with an auto-incrementing byte address. It is the counterpart of the core's decode/control path, and it is used by the boot loader and the test harness to build program images in instruction memory.

---
 rtl/rv_enc_pkg.sv | 52 +++++
 rtl/enc_fifo.sv | 52 +++++
 rtl/instr_encoder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rv_enc_pkg.sv
// Shared kinds, opcode/funct constants and immediate limits for instr_encoder.
package rv_enc_pkg;

  typedef enum logic [3:0] {
    K_LD     = 4'd0,
    K_SD     = 4'd1,
    K_ADD    = 4'd2,
    K_SUB    = 4'd3,
    K_AND    = 4'd4,
    K_OR     = 4'd5,
    K_ADDI   = 4'd6,
    K_BEQ    = 4'd7,
    K_JAL    = 4'd8,
    K_SH1ADD = 4'd9,
    K_SH2ADD = 4'd10,
    K_SH3ADD = 4'd11
  } enc_kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_LD     = 3'b011;
  localparam logic [2:0] F3_SD     = 3'b011;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SUB    = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_SH1ADD = 3'b010;
  localparam logic [2:0] F3_SH2ADD = 3'b100;
  localparam logic [2:0] F3_SH3ADD = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_ZBA  = 7'b0010000;

  // 12-bit I/S immediates and 13-bit (even) branch offsets
  localparam int IMM12_MIN  = -2048;
  localparam int IMM12_MAX  = 2047;
  localparam int BR_IMM_MIN = -4096;
  localparam int BR_IMM_MAX = 4094;

  typedef struct packed {
    logic        ok;
    logic [31:0] word;
  } enc_result_t;

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO with flush for encoded words; DEPTH must be a power of two.
module enc_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV64I+Zba encoder: symbolic requests in, 32-bit words out to imem.
// Define INSTR_ENCODER_ZBA_EN to encode SH1ADD/SH2ADD/SH3ADD; otherwise they are rejected.
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_kind,
  input  logic [4:0]         req_rd,
  input  logic [4:0]         req_rs1,
  input  logic [4:0]         req_rs2,
  input  logic signed [20:0] req_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               err,
  output logic [ADDR_W-2:0]  word_count
);

  import rv_enc_pkg::*;

  function automatic logic in_range(input logic signed [20:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // Branch/jump offsets are even, so bit 0 never reaches the word
  function automatic logic [31:0] b_type(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  function automatic enc_result_t encode(input enc_kind_e kind, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic signed [20:0] imm);
    enc_result_t r;
    r.ok   = 1'b1;
    r.word = '0;
    case (kind)
      K_LD: begin
        r.ok   = in_range(imm, IMM12_MIN, IMM12_MAX);
        r.word = i_type(imm[11:0], rs1, F3_LD, rd, OP_LOAD);
      end
      K_SD: begin
        r.ok   = in_range(imm, IMM12_MIN, IMM12_MAX);
        r.word = s_type(imm[11:0], rs2, rs1, F3_SD, OP_STORE);
      end
      K_ADD:  r.word = r_type(F7_BASE, rs2, rs1, F3_ADD, rd, OP_OP);
      K_SUB:  r.word = r_type(F7_SUB,  rs2, rs1, F3_SUB, rd, OP_OP);
      K_AND:  r.word = r_type(F7_BASE, rs2, rs1, F3_AND, rd, OP_OP);
      K_OR:   r.word = r_type(F7_BASE, rs2, rs1, F3_OR,  rd, OP_OP);
      K_ADDI: begin
        r.ok   = in_range(imm, IMM12_MIN, IMM12_MAX);
        r.word = i_type(imm[11:0], rs1, F3_ADD, rd, OP_IMM);
      end
      K_BEQ: begin
        r.ok   = in_range(imm, BR_IMM_MIN, BR_IMM_MAX) && !imm[0];
        r.word = b_type(imm[12:1], rs2, rs1);
      end
      K_JAL: begin
        r.ok   = !imm[0];
        r.word = j_type(imm[20:1], rd);
      end
`ifdef INSTR_ENCODER_ZBA_EN
      K_SH1ADD: r.word = r_type(F7_ZBA, rs2, rs1, F3_SH1ADD, rd, OP_OP);
      K_SH2ADD: r.word = r_type(F7_ZBA, rs2, rs1, F3_SH2ADD, rd, OP_OP);
      K_SH3ADD: r.word = r_type(F7_ZBA, rs2, rs1, F3_SH3ADD, rd, OP_OP);
`endif
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

  enc_result_t       enc;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic [31:0]       head;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-2:0] count_q;
  logic              err_q;

  assign enc = encode(enc_kind_e'(req_kind), req_rd, req_rs1, req_rs2, req_imm);

  // Ready depends only on registered occupancy and clear, never on out_ready
  assign req_ready = !full && !clear;
  assign accept    = req_valid && req_ready;
  assign push      = accept && enc.ok;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready && !clear;

  enc_fifo #(
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .push    (push),
    .pop     (pop),
    .wr_data (enc.word),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // FIFO storage is not reset, so mask the head while nothing is queued
  assign out_data = empty ? 32'h0 : head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= ADDR_W'(BASE_ADDR);
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clear) begin
      addr_q  <= ADDR_W'(BASE_ADDR);
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (pop) begin
        addr_q  <= addr_q + ADDR_W'(4);
        count_q <= count_q + {{(ADDR_W-2){1'b0}}, 1'b1};
      end
      if (accept && !enc.ok) err_q <= 1'b1;
    end
  end

  assign out_addr   = addr_q;
  assign word_count = count_q;
  assign err        = err_q;

endmodule
